// File: rtl/motion_event_detector.sv
// ----------------------------------------------------------------------------
// motion_event_detector
//
// Samples the accelerometer X/Y/Z axes on a free-running tick. For each
// sample it computes activity (the sum of absolute axis deltas), smooths it
// with an exponential moving average, detects shaking with hysteresis and
// classifies the dominant tilt direction.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   X/Y/Z_Accel   signed 16-bit accelerations, same clock domain, no strobe
//   activity      |dX|+|dY|+|dZ| of the latest sample (18-bit unsigned)
//   activity_avg  EMA of activity (18-bit unsigned)
//   shaking       hysteretic shake level
//   shake_pulse   one-cycle pulse on shaking 0->1, coincident with result_valid
//   tilt_code     0 none, 1 +X, 2 -X, 3 +Y, 4 -Y, 5 +Z, 6 -Z
//   result_valid  one-cycle pulse when all outputs have been updated
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | wait for the sample tick
// S_CAP    | capture X/Y/Z into cur_*
// S_DIFF   | register |cur - prev| and |cur| per axis
// S_SUM    | register activity (0 until primed) and the tilt code
// S_FILT   | EMA update; outputs, prev_*, primed and shake state are loaded
//          | at the edge leaving this state
// S_DECIDE | outputs valid, result_valid/shake_pulse high; back to S_IDLE
// ----------------------------------------------------------------------------
module motion_event_detector #(
   parameter int          SAMPLE_DIV = 500000,
   parameter int          AVG_LOG2   = 3,
   parameter logic [17:0] HI_THRESH  = 18'd4000,
   parameter logic [17:0] LO_THRESH  = 18'd1500,
   parameter logic [15:0] TILT_MIN   = 16'd2000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] X_Accel,
   input  logic [15:0] Y_Accel,
   input  logic [15:0] Z_Accel,
   output logic [17:0] activity,
   output logic [17:0] activity_avg,
   output logic        shaking,
   output logic        shake_pulse,
   output logic [2:0]  tilt_code,
   output logic        result_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAP,
      S_DIFF,
      S_SUM,
      S_FILT,
      S_DECIDE
   } state_t;

   localparam logic [19:0] DIV_M1 = 20'(SAMPLE_DIV - 1);

   state_t      state;
   logic [19:0] tick_cnt;
   logic        tick;

   logic [15:0] cur_x, cur_y, cur_z;
   logic [15:0] prev_x, prev_y, prev_z;
   logic [15:0] adx_r, ady_r, adz_r;
   logic [15:0] acx_r, acy_r, acz_r;
   logic [17:0] act_r;
   logic [2:0]  tilt_r;
   logic        primed;

   logic [16:0] dx, dy, dz;
   logic [15:0] adx, ady, adz;
   logic [15:0] acx, acy, acz;
   logic [17:0] sum_act;
   logic [2:0]  tilt_nxt;
   logic [15:0] dom_mag;
   logic signed [18:0] ema_diff;
   logic signed [18:0] ema_step;
   logic signed [19:0] ema_sum;
   logic [17:0] avg_new;

   // Tick counter free-runs regardless of the FSM.
   assign tick = (tick_cnt == DIV_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 20'd1;
      end
   end

   // Deltas are formed at 17 bits so a full-scale swing cannot wrap; the
   // magnitude of a 17-bit value in [-65535, 65535] always fits 16 bits.
   always_comb begin
      dx  = {cur_x[15], cur_x} - {prev_x[15], prev_x};
      dy  = {cur_y[15], cur_y} - {prev_y[15], prev_y};
      dz  = {cur_z[15], cur_z} - {prev_z[15], prev_z};
      adx = dx[16] ? (~dx[15:0] + 16'd1) : dx[15:0];
      ady = dy[16] ? (~dy[15:0] + 16'd1) : dy[15:0];
      adz = dz[16] ? (~dz[15:0] + 16'd1) : dz[15:0];
      // |-32768| reads as 32768 once taken as unsigned.
      acx = cur_x[15] ? (~cur_x + 16'd1) : cur_x;
      acy = cur_y[15] ? (~cur_y + 16'd1) : cur_y;
      acz = cur_z[15] ? (~cur_z + 16'd1) : cur_z;
   end

   always_comb begin
      sum_act = {2'b00, adx_r} + {2'b00, ady_r} + {2'b00, adz_r};
      // Ties favour X over Y over Z; a zero axis counts as positive.
      if (acx_r >= acy_r && acx_r >= acz_r) begin
         dom_mag  = acx_r;
         tilt_nxt = cur_x[15] ? 3'd2 : 3'd1;
      end else if (acy_r >= acz_r) begin
         dom_mag  = acy_r;
         tilt_nxt = cur_y[15] ? 3'd4 : 3'd3;
      end else begin
         dom_mag  = acz_r;
         tilt_nxt = cur_z[15] ? 3'd6 : 3'd5;
      end
      if (dom_mag < TILT_MIN) begin
         tilt_nxt = 3'd0;
      end
   end

   // EMA: arithmetic shift floors toward negative, result clamped to 18 bits.
   always_comb begin
      ema_diff = $signed({1'b0, act_r}) - $signed({1'b0, activity_avg});
      ema_step = ema_diff >>> AVG_LOG2;
      ema_sum  = $signed({2'b00, activity_avg}) + $signed({ema_step[18], ema_step});
      if (!primed) begin
         avg_new = activity_avg;
      end else if (ema_sum[19]) begin
         avg_new = '0;
      end else if (ema_sum[18]) begin
         avg_new = '1;
      end else begin
         avg_new = ema_sum[17:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cur_x        <= '0;
         cur_y        <= '0;
         cur_z        <= '0;
         prev_x       <= '0;
         prev_y       <= '0;
         prev_z       <= '0;
         adx_r        <= '0;
         ady_r        <= '0;
         adz_r        <= '0;
         acx_r        <= '0;
         acy_r        <= '0;
         acz_r        <= '0;
         act_r        <= '0;
         tilt_r       <= '0;
         primed       <= 1'b0;
         activity     <= '0;
         activity_avg <= '0;
         shaking      <= 1'b0;
         shake_pulse  <= 1'b0;
         tilt_code    <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         shake_pulse  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tick) begin
                  state <= S_CAP;
               end
            end
            S_CAP: begin
               cur_x <= X_Accel;
               cur_y <= Y_Accel;
               cur_z <= Z_Accel;
               state <= S_DIFF;
            end
            S_DIFF: begin
               adx_r <= adx;
               ady_r <= ady;
               adz_r <= adz;
               acx_r <= acx;
               acy_r <= acy;
               acz_r <= acz;
               state <= S_SUM;
            end
            S_SUM: begin
               act_r  <= primed ? sum_act : 18'd0;
               tilt_r <= tilt_nxt;
               state  <= S_FILT;
            end
            S_FILT: begin
               activity     <= act_r;
               activity_avg <= avg_new;
               tilt_code    <= tilt_r;
               prev_x       <= cur_x;
               prev_y       <= cur_y;
               prev_z       <= cur_z;
               primed       <= 1'b1;
               result_valid <= 1'b1;
               if (primed) begin
                  if (!shaking && avg_new >= HI_THRESH) begin
                     shaking     <= 1'b1;
                     shake_pulse <= 1'b1;
                  end else if (avg_new < LO_THRESH) begin
                     shaking <= 1'b0;
                  end
               end
               state <= S_DECIDE;
            end
            S_DECIDE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
